dmem_arbiter: RTL

Sequences the single-port data memory shared by the MEM pipeline stage and the program/debug loader port. Adds configurable wait states for slow memory, stalls the pipeline until its access completes, and guarantees the loader bounded access under heavy pipeline traffic. It sits between the MEM stage control (Rm/Wm, address from the accumulator, store value from the register file) and the data memory array.

---
 rtl/dmem_arbiter_if.sv | 29 ++
 rtl/dmem_arbiter.sv | 80 ++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: pipeline, loader and memory-array signals of the data-memory arbiter.
interface dmem_arbiter_if;
  logic       pipe_rd;
  logic       pipe_wr;
  logic [7:0] pipe_addr;
  logic [7:0] pipe_wdata;
  logic [7:0] pipe_rdata;
  logic       pipe_stall;
  logic       ldr_req;
  logic       ldr_we;
  logic [7:0] ldr_addr;
  logic [7:0] ldr_wdata;
  logic       ldr_gnt;
  logic       ldr_done;
  logic [7:0] ldr_rdata;
  logic       mem_rm;
  logic       mem_wm;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  modport slave (
    input  pipe_rd, pipe_wr, pipe_addr, pipe_wdata, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
    output pipe_rdata, pipe_stall, ldr_gnt, ldr_done, ldr_rdata, mem_rm, mem_wm, mem_addr, mem_wdata
  );
  modport master (
    output pipe_rd, pipe_wr, pipe_addr, pipe_wdata, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
    input  pipe_rdata, pipe_stall, ldr_gnt, ldr_done, ldr_rdata, mem_rm, mem_wm, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the MEM stage and the loader,
// with wait states, pipeline stall and a starvation bound for the loader.
module dmem_arbiter #(
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          clock,
  input logic          reset_n,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PIPE_ACC, LDR_ACC} state_t;
  state_t     r_state;
  logic [2:0] r_cnt;
  logic [3:0] r_starve;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_we;
  logic [7:0] r_pipe_rdata;
  logic [7:0] r_ldr_rdata;
  logic       r_ldr_done;
  logic       w_idle;
  logic       w_last;
  logic       w_pipe_req;
  logic       w_ldr_req;
  logic       w_starved;
  logic       w_go_ldr;
  logic       w_go_pipe;
  assign w_idle     = r_state == IDLE;
  assign w_last     = r_cnt == 3'(WAIT_STATES);
  assign w_pipe_req = bus.pipe_rd | bus.pipe_wr;
  // the loader's request is still visible while its done pulse is out; skip it then
  assign w_ldr_req  = bus.ldr_req & ~r_ldr_done;
  assign w_starved  = r_starve == 4'(STARVE_LIMIT);
  assign w_go_ldr   = w_ldr_req & (w_starved | ~w_pipe_req);
  assign w_go_pipe  = w_pipe_req & ~(w_ldr_req & w_starved);
  assign bus.pipe_stall = w_pipe_req & ~(r_state == PIPE_ACC & w_last);
  assign bus.mem_rm     = ~w_idle & ~r_we;
  assign bus.mem_wm     = ~w_idle & r_we;
  assign bus.mem_addr   = w_idle ? 8'h00 : r_addr;
  assign bus.mem_wdata  = w_idle ? 8'h00 : r_wdata;
  assign bus.ldr_gnt    = r_state == LDR_ACC;
  assign bus.ldr_done   = r_ldr_done;
  assign bus.pipe_rdata = r_pipe_rdata;
  assign bus.ldr_rdata  = r_ldr_rdata;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= 3'd0;
      r_starve     <= 4'd0;
      r_addr       <= 8'h00;
      r_wdata      <= 8'h00;
      r_we         <= 1'b0;
      r_pipe_rdata <= 8'h00;
      r_ldr_rdata  <= 8'h00;
      r_ldr_done   <= 1'b0;
    end else begin
      r_ldr_done <= 1'b0;
      if (w_idle) begin
        r_cnt <= 3'd0;
        if (w_go_ldr || w_go_pipe) begin
          r_state <= w_go_ldr ? LDR_ACC : PIPE_ACC;
          r_addr  <= w_go_ldr ? bus.ldr_addr : bus.pipe_addr;
          r_wdata <= w_go_ldr ? bus.ldr_wdata : bus.pipe_wdata;
          r_we    <= w_go_ldr ? bus.ldr_we : bus.pipe_wr;
        end
        // a pipeline grant while the loader waits is always below the limit here
        r_starve <= (w_go_ldr || !bus.ldr_req) ? 4'd0 :
                    (w_go_pipe && w_ldr_req) ? r_starve + 4'd1 : r_starve;
      end else if (w_last) begin
        r_state    <= IDLE;
        r_cnt      <= 3'd0;
        r_ldr_done <= r_state == LDR_ACC;
        if (!r_we && r_state == PIPE_ACC) r_pipe_rdata <= bus.mem_rdata;
        if (!r_we && r_state == LDR_ACC) r_ldr_rdata <= bus.mem_rdata;
      end else begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end
endmodule
